// File: rtl/tqvp_integrator_pkg.sv
// Shared constants for the multi-channel integrator peripheral:
// register map, CTRL/STATUS bit positions and reset defaults.
package tqvp_integrator_pkg;

  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_CHSEL    = 4'h1;
  localparam logic [3:0] A_INPUT    = 4'h2;
  localparam logic [3:0] A_SHIFT    = 4'h3;
  localparam logic [3:0] A_THR_LO   = 4'h4;
  localparam logic [3:0] A_THR_HI   = 4'h5;
  localparam logic [3:0] A_STATUS   = 4'h6;
  localparam logic [3:0] A_SNAP_CMD = 4'h7;
  localparam logic [3:0] A_SNAP0    = 4'h8;
  localparam logic [3:0] A_SNAP1    = 4'h9;
  localparam logic [3:0] A_SNAP2    = 4'hA;
  localparam logic [3:0] A_SNAP3    = 4'hB;
  localparam logic [3:0] A_PEND     = 4'hC;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_LEAKY = 1;
  localparam int CTRL_SAT   = 2;
  localparam int CTRL_EXT   = 3;
  localparam int CTRL_IRQ   = 4;
  localparam int CTRL_CLR   = 5;

  localparam int ST_OVF  = 0;
  localparam int ST_THR  = 1;
  localparam int ST_DROP = 2;
  localparam int ST_PEND = 3;

  localparam logic [4:0] SHIFT_RST = 5'd4;

endpackage

// File: rtl/tqvp_integrator_alu.sv
// Shared accumulate datapath: normal or leaky update in ACC_W+1 bits,
// overflow detection and optional saturation back to ACC_W bits.
module integrator_alu #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  sample,
  input  logic             leaky,
  input  logic [4:0]       shift,
  input  logic             sat_en,
  output logic [ACC_W-1:0] next,
  output logic             ovf
);
  localparam int W1 = ACC_W + 1;

  logic signed [ACC_W:0] acc_x, s_x, decay, sum;

  // One extra guard bit makes the out-of-range test a simple sign compare.
  always_comb begin
    acc_x = W1'($signed(acc));
    s_x   = W1'($signed(sample));
    decay = leaky ? (acc_x >>> shift) : '0;
    sum   = acc_x - decay + s_x;
    ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    next  = sum[ACC_W-1:0];
    if (ovf && sat_en)
      next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

endmodule

// File: rtl/tqvp_integrator_mc.sv
// Multi-channel integrator behind the TinyQV peripheral bus. NCH signed
// accumulators share one ALU through a free-running round-robin pointer;
// each channel has a one-deep pending-sample buffer.
module tqvp_integrator_mc
  import tqvp_integrator_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       user_interrupt
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [4:0]    ctrl;
  logic [CW-1:0] chsel, ptr;
  logic [7:0]    input_q;
  logic [4:0]    shift;
  logic [15:0]   thresh;
  logic [ACC_W-1:0] snap;
  logic [2:0]    sync;

  logic [NCH-1:0][ACC_W-1:0] acc;
  logic [NCH-1:0][IN_W-1:0]  samp;
  logic [NCH-1:0] pend, ovf, drop, thr;
  logic [NCH-1:0] hit_q, hit_s, st_sel;

  logic wr_ctrl, wr_status, clr_now, ext, ext_rise, q_req, svc;
  logic [IN_W-1:0]  q_data;
  logic [ACC_W-1:0] alu_next;
  logic             alu_ovf;
  logic signed [ACC_W-1:0] thr_x;
  logic [31:0] snap_x;
  logic unused_ui;

  assign unused_ui = ui_in[6];

  assign wr_ctrl   = data_write && (address == A_CTRL);
  assign wr_status = data_write && (address == A_STATUS);
  assign clr_now   = wr_ctrl && data_in[CTRL_CLR];
  assign ext       = ctrl[CTRL_EXT];
  assign ext_rise  = sync[1] & ~sync[2];
  assign q_req     = ext ? ext_rise : (data_write && (address == A_INPUT));
  assign q_data    = ext ? IN_W'({2'b00, ui_in[5:0]}) : IN_W'(data_in);
  // clr takes the whole edge, so nothing is consumed alongside it.
  assign svc       = ctrl[CTRL_EN] && pend[ptr] && !clr_now;

  integrator_alu #(.IN_W(IN_W), .ACC_W(ACC_W)) u_alu (
    .acc    (acc[ptr]),
    .sample (samp[ptr]),
    .leaky  (ctrl[CTRL_LEAKY]),
    .shift  (shift),
    .sat_en (ctrl[CTRL_SAT]),
    .next   (alu_next),
    .ovf    (alu_ovf)
  );

  // Per-channel decode of queue, service and status-write hits.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit_q[i]  = q_req && (chsel == CW'(i));
      hit_s[i]  = svc && (ptr == CW'(i));
      st_sel[i] = wr_status && (chsel == CW'(i));
    end
  end

  // Configuration registers, synchroniser, scheduler pointer and snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      chsel   <= '0;
      input_q <= '0;
      shift   <= SHIFT_RST;
      thresh  <= '0;
      snap    <= '0;
      sync    <= '0;
      ptr     <= '0;
    end else begin
      sync <= {sync[1:0], ui_in[7]};
      ptr  <= (ptr == CW'(NCH-1)) ? '0 : ptr + 1'b1;
      if (data_write) begin
        case (address)
          A_CTRL:     ctrl <= data_in[4:0];
          A_CHSEL:    chsel <= CW'(data_in % NCH);
          A_INPUT:    if (!ext) input_q <= data_in;
          A_SHIFT:    shift <= (data_in > 8'(ACC_W-1)) ? 5'(ACC_W-1) : data_in[4:0];
          A_THR_LO:   thresh[7:0] <= data_in;
          A_THR_HI:   thresh[15:8] <= data_in;
          A_SNAP_CMD: snap <= acc[chsel];
          default: ;
        endcase
      end
    end
  end

  // Channel state: a queue hit on the channel being serviced keeps pend
  // set (new sample waits) without flagging a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      samp <= '0;
      pend <= '0;
      ovf  <= '0;
      drop <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit_q[i]) samp[i] <= q_data;
        if (clr_now) begin
          acc[i]  <= '0;
          pend[i] <= 1'b0;
          ovf[i]  <= 1'b0;
        end else begin
          if (hit_s[i]) acc[i] <= alu_next;
          if (hit_q[i])      pend[i] <= 1'b1;
          else if (hit_s[i]) pend[i] <= 1'b0;
          if (hit_s[i] && alu_ovf)                ovf[i] <= 1'b1;
          else if (st_sel[i] && data_in[ST_OVF])  ovf[i] <= 1'b0;
        end
        if (hit_q[i] && pend[i] && !hit_s[i])    drop[i] <= 1'b1;
        else if (st_sel[i] && data_in[ST_DROP])  drop[i] <= 1'b0;
      end
    end
  end

  // Signed threshold compare per channel.
  always_comb begin
    thr_x = ACC_W'($signed(thresh));
    for (int i = 0; i < NCH; i++)
      thr[i] = $signed(acc[i]) > thr_x;
  end

  assign snap_x = 32'($signed(snap));

  // Register read mux.
  always_comb begin
    data_out = '0;
    case (address)
      A_CTRL:     data_out = {3'b000, ctrl};
      A_CHSEL:    data_out = 8'(chsel);
      A_INPUT:    data_out = input_q;
      A_SHIFT:    data_out = {3'b000, shift};
      A_THR_LO:   data_out = thresh[7:0];
      A_THR_HI:   data_out = thresh[15:8];
      A_STATUS:   data_out = {4'b0000, pend[chsel], drop[chsel], thr[chsel], ovf[chsel]};
      A_SNAP_CMD: data_out = 8'(ovf);
      A_SNAP0:    data_out = snap_x[7:0];
      A_SNAP1:    data_out = snap_x[15:8];
      A_SNAP2:    data_out = snap_x[23:16];
      A_SNAP3:    data_out = snap_x[31:24];
      A_PEND:     data_out = 8'(pend);
      default:    data_out = '0;
    endcase
  end

  assign uo_out         = acc[chsel][ACC_W-1 -: 8];
  assign user_interrupt = ctrl[CTRL_IRQ] && |(ovf | thr);

endmodule

// File: tb/tb_tqvp_integrator_mc.sv
// Directed bench: a 24-bit instance for the main sequence and a 16-bit
// instance for saturation/wrap (keeps the fill loop short).
module tb_tqvp_integrator_mc;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] ui_in, data_in;
  logic [3:0] address;
  logic data_write, sel16;
  logic [7:0] uo24, uo16, do24, do16, dout, uo;
  logic irq24, irq16, irq;

  always #5 clk = ~clk;

  assign dout = sel16 ? do16 : do24;
  assign uo   = sel16 ? uo16 : uo24;
  assign irq  = sel16 ? irq16 : irq24;

  tqvp_integrator_mc #(.NCH(4), .IN_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo24), .address(address),
    .data_write(data_write & ~sel16), .data_in(data_in), .data_out(do24),
    .user_interrupt(irq24));

  tqvp_integrator_mc #(.NCH(4), .IN_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .ui_in(8'h00), .uo_out(uo16), .address(address),
    .data_write(data_write & sel16), .data_in(data_in), .data_out(do16),
    .user_interrupt(irq16));

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_v(tag, exp);
    cmp(obs);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] exp);
    expect_v(tag, exp);
    @(negedge clk);
    address = a;
    #1;
    cmp(32'(dout));
  endtask

  // Snapshot channel ch and compare the sign-filled 32-bit readback.
  task automatic snap(input int ch, input string tag, input logic [31:0] exp);
    logic [31:0] v;
    wr(4'h1, 8'(ch));
    wr(4'h7, 8'h00);
    expect_v(tag, exp);
    address = 4'h8; #1; v[7:0]   = dout;
    address = 4'h9; #1; v[15:8]  = dout;
    address = 4'hA; #1; v[23:16] = dout;
    address = 4'hB; #1; v[31:24] = dout;
    cmp(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; ui_in = 8'h00; data_in = 8'h00; address = 4'h0;
    data_write = 1'b0; sel16 = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    rd(4'h0, "rst_ctrl", 32'h0);
    rd(4'h3, "rst_shift", 32'h4);
    rd(4'hC, "rst_pend", 32'h0);
    rd(4'h8, "rst_snap0", 32'h0);
    chk("rst_uo", 32'(uo), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Basic accumulate on channel 2
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h02);
    for (int i = 0; i < 3; i++) begin
      wr(4'h2, 8'h05);
      idle(8);
    end
    rd(4'h2, "input_rb", 32'h05);
    snap(2, "acc2_sum", 32'h0000000F);
    snap(0, "acc0_idle", 32'h0);
    snap(1, "acc1_idle", 32'h0);
    snap(3, "acc3_idle", 32'h0);

    // Boundaries: CHSEL wrap, DECAY_SHIFT clamp
    wr(4'h1, 8'h06);
    rd(4'h1, "chsel_wrap", 32'h2);
    wr(4'h3, 8'hFF);
    rd(4'h3, "shift_clamp", 32'd23);
    wr(4'h3, 8'h04);

    // Held pending and drop with en=0
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h01);
    wr(4'h2, 8'h10);
    wr(4'h2, 8'h20);
    rd(4'h6, "st_drop_pend", 32'h0C);
    rd(4'hC, "pend_bitmap", 32'h02);
    wr(4'h0, 8'h01);
    idle(6);
    snap(1, "acc1_overwrite", 32'h00000020);
    rd(4'h6, "st_after_svc", 32'h06);
    wr(4'h6, 8'h04);
    rd(4'h6, "st_drop_w1c", 32'h02);

    // Saturation and wrap on the 16-bit instance
    sel16 = 1'b1;
    wr(4'h0, 8'h35);
    wr(4'h1, 8'h00);
    chk("sat_irq_before", 32'(irq), 32'h0);
    for (int i = 0; i < 260; i++) begin
      wr(4'h2, 8'h7F);
      idle(5);
    end
    snap(0, "sat_acc0", 32'h00007FFF);
    rd(4'h7, "sat_ovf_bm", 32'h1);
    chk("sat_uo", 32'(uo), 32'h7F);
    chk("sat_irq", 32'(irq), 32'h1);
    wr(4'h0, 8'h31);
    rd(4'h7, "clr_ovf_bm", 32'h0);
    for (int i = 0; i < 259; i++) begin
      wr(4'h2, 8'h7F);
      idle(5);
    end
    snap(0, "wrap_acc0", 32'hFFFF807D);
    rd(4'h7, "wrap_ovf_bm", 32'h1);
    sel16 = 1'b0;

    // Leaky mode
    wr(4'h0, 8'h21);
    wr(4'h1, 8'h00);
    wr(4'h2, 8'h40);
    idle(6);
    snap(0, "leaky_seed", 32'h00000040);
    wr(4'h3, 8'h01);
    wr(4'h0, 8'h03);
    wr(4'h2, 8'h00);
    idle(6);
    snap(0, "leaky_decay", 32'h00000020);
    wr(4'h2, 8'h80);
    idle(6);
    snap(0, "leaky_neg", 32'hFFFFFF90);

    // External strobe mode
    wr(4'h3, 8'h04);
    wr(4'h0, 8'h29);
    wr(4'h1, 8'h03);
    ui_in = 8'h3F;
    idle(3);
    ui_in = 8'hBF;
    idle(7);
    snap(3, "ext_acc3", 32'h0000003F);
    wr(4'h2, 8'h11);
    idle(6);
    snap(3, "ext_input_ignored", 32'h0000003F);
    rd(4'hC, "ext_pend", 32'h0);
    ui_in = 8'h00;

    // Queue write coinciding with service of channel 0
    wr(4'h0, 8'h21);
    wr(4'h1, 8'h00);
    wr(4'h2, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      address = 4'hC;
      #1;
      if (dout[0] == 1'b0) found = 1'b1;
    end
    chk("sim_svc_seen", 32'(found), 32'h1);
    address = 4'h2; data_in = 8'h03; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    idle(2);
    address = 4'h2; data_in = 8'h04; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    rd(4'h6, "sim_no_drop", 32'h0A);
    idle(6);
    snap(0, "sim_acc0", 32'h00000008);

    // clr mid-stream: accs/pend/ovf cleared, drop kept
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h01);
    wr(4'h2, 8'h07);
    wr(4'h2, 8'h08);
    wr(4'h1, 8'h02);
    wr(4'h2, 8'h09);
    rd(4'hC, "pre_clr_pend", 32'h06);
    wr(4'h0, 8'h21);
    rd(4'hC, "clr_pend", 32'h0);
    wr(4'h1, 8'h01);
    rd(4'h6, "clr_keep_drop", 32'h04);
    snap(0, "clr_acc0", 32'h0);

    // Reset mid-stream
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h02);
    wr(4'h2, 8'h05);
    wr(4'h3, 8'h09);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(4'hC, "rst2_pend", 32'h0);
    rd(4'h0, "rst2_ctrl", 32'h0);
    rd(4'h3, "rst2_shift", 32'h4);
    rd(4'h1, "rst2_chsel", 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    for (int c = 0; c < 4; c++) snap(c, "rst2_acc", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
